// File: rtl/fetch_queue.sv
// In-order instruction buffer between fetch and decode: DEPTH-entry circular queue
// of {pc, instr} with wrap-bit pointers, flush, and NOP-forced head when empty.
module fetch_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = 64
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_instr_valid,
  input  logic [31:0]                i_instr,
  input  logic [XLEN-1:0]            i_pc,
  output logic                       o_instr_ready,
  output logic                       o_valid,
  output logic [31:0]                o_instr,
  output logic [XLEN-1:0]            o_pc,
  output logic [6:0]                 o_op,
  output logic [2:0]                 o_func3,
  output logic                       o_func7_5,
  input  logic                       i_decode_stall,
  input  logic                       i_flush,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } entry_t;

  entry_t        mem_q [DEPTH];
  entry_t        head;
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]   occupancy;
  logic          push;
  logic          pop;

  // Equal index with differing wrap bits means the writer has lapped the reader.
  assign o_empty   = (wr_ptr_q == rd_ptr_q);
  assign o_full    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                     (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign occupancy = wr_ptr_q - rd_ptr_q;
  assign o_count   = CW'(occupancy);

  assign o_instr_ready = !o_full;
  assign o_valid       = !o_empty;

  assign push = i_instr_valid && o_instr_ready;
  assign pop  = o_valid && !i_decode_stall;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage has no reset; entries are only observed when the pointers
  // say they are valid, so clearing them would cost logic for no behaviour.
  always_ff @(posedge i_clk) begin
    if (push && !i_flush && !i_rst) begin
      mem_q[wr_ptr_q[AW-1:0]] <= '{pc: i_pc, instr: i_instr};
    end
  end

  assign head = mem_q[rd_ptr_q[AW-1:0]];

  // Empty queue presents addi x0,x0,0 so decode never sees stale data.
  assign o_instr   = o_empty ? NOP : head.instr;
  assign o_pc      = o_empty ? '0  : head.pc;
  assign o_op      = o_instr[6:0];
  assign o_func3   = o_instr[14:12];
  assign o_func7_5 = o_instr[30];

endmodule

// File: tb/tb_fetch_queue.sv
// Directed plus randomized bench for fetch_queue, checked against a queue-based model.
module tb_fetch_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned XLEN  = 64;

  typedef struct {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } ent_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              instr_valid;
  logic [31:0]       instr;
  logic [XLEN-1:0]   pc;
  logic              instr_ready;
  logic              valid;
  logic [31:0]       head_instr;
  logic [XLEN-1:0]   head_pc;
  logic [6:0]        op;
  logic [2:0]        func3;
  logic              func7_5;
  logic              decode_stall;
  logic              flush;
  logic              full;
  logic              empty;
  logic [2:0]        count;

  int n_cmp = 0;
  int n_err = 0;
  ent_t model_q[$];

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_instr_valid  (instr_valid),
    .i_instr        (instr),
    .i_pc           (pc),
    .o_instr_ready  (instr_ready),
    .o_valid        (valid),
    .o_instr        (head_instr),
    .o_pc           (head_pc),
    .o_op           (op),
    .o_func3        (func3),
    .o_func7_5      (func7_5),
    .i_decode_stall (decode_stall),
    .i_flush        (flush),
    .o_full         (full),
    .o_empty        (empty),
    .o_count        (count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected head/status derived from the model's queue contents.
  task automatic check_all(input string tag);
    logic [31:0]     e_instr;
    logic [XLEN-1:0] e_pc;
    int              n;
    n       = model_q.size();
    e_instr = (n > 0) ? model_q[0].instr : 32'h0000_0013;
    e_pc    = (n > 0) ? model_q[0].pc : '0;
    chk({tag, ".count"}, 64'(count), 64'(n));
    chk({tag, ".empty"}, 64'(empty), 64'(n == 0));
    chk({tag, ".full"},  64'(full),  64'(n == DEPTH));
    chk({tag, ".valid"}, 64'(valid), 64'(n != 0));
    chk({tag, ".ready"}, 64'(instr_ready), 64'(n != DEPTH));
    chk({tag, ".instr"}, 64'(head_instr), 64'(e_instr));
    chk({tag, ".pc"},    64'(head_pc), 64'(e_pc));
    chk({tag, ".op"},    64'(op), 64'(e_instr[6:0]));
    chk({tag, ".func3"}, 64'(func3), 64'(e_instr[14:12]));
    chk({tag, ".f7_5"},  64'(func7_5), 64'(e_instr[30]));
  endtask

  // Drive one cycle, check the pre-edge outputs, then advance the model.
  task automatic step(input string tag, input bit v, input logic [31:0] ins,
                      input logic [XLEN-1:0] p, input bit st, input bit fl, input bit rs);
    bit do_push, do_pop;
    instr_valid  = v;
    instr        = ins;
    pc           = p;
    decode_stall = st;
    flush        = fl;
    rst          = rs;
    #1;
    check_all(tag);
    do_push = v && (model_q.size() < DEPTH);
    do_pop  = !st && (model_q.size() > 0);
    @(posedge clk);
    if (rs || fl) begin
      model_q.delete();
    end else begin
      if (do_pop)  void'(model_q.pop_front());
      if (do_push) model_q.push_back('{pc: p, instr: ins});
    end
    #1;
  endtask

  initial begin
    logic [31:0] prog [4];
    prog[0] = 32'h0050_0093;
    prog[1] = 32'h00A0_0113;
    prog[2] = 32'h0020_81B3;
    prog[3] = 32'h4020_8233;

    rst = 1'b1; instr_valid = 1'b0; instr = '0; pc = '0;
    decode_stall = 1'b0; flush = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    model_q.delete();

    // Reset state
    step("reset", 0, 32'h0, 64'h0, 0, 0, 1);

    // Fill under stall, then a refused 5th push, then drain in order
    for (int i = 0; i < 4; i++) step("fill", 1, prog[i], 64'(i * 4), 1, 0, 0);
    step("push_full", 1, 32'hDEAD_BEEF, 64'h10, 1, 0, 0);
    step("full_pop_push", 1, 32'hCAFE_0013, 64'h14, 0, 0, 0);
    for (int i = 0; i < 4; i++) step("drain", 0, 32'h0, 64'h0, 0, 0, 0);
    step("pop_empty", 0, 32'h0, 64'h0, 0, 0, 0);

    // count=2 then simultaneous push and pop
    step("two_a", 1, 32'h0010_0093, 64'h100, 1, 0, 0);
    step("two_b", 1, 32'h0020_0113, 64'h104, 1, 0, 0);
    step("pushpop", 1, 32'h0030_0193, 64'h108, 0, 0, 0);
    step("after_pp", 0, 32'h0, 64'h0, 1, 0, 0);
    step("flush_clr", 0, 32'h0, 64'h0, 0, 1, 0);

    // Ten push/pop pairs with one entry resident, wrapping the pointers
    step("wrap_seed", 1, 32'h0000_1013, 64'h200, 1, 0, 0);
    for (int i = 0; i < 10; i++)
      step("wrap", 1, 32'h4000_0033 | 32'(i << 12), 64'h204 + 64'(i * 4), 0, 0, 0);
    step("wrap_end", 0, 32'h0, 64'h0, 0, 0, 0);
    step("wrap_end2", 0, 32'h0, 64'h0, 0, 0, 0);

    // Flush at count=3 with a push in the same cycle
    for (int i = 0; i < 3; i++) step("pre_flush", 1, prog[i], 64'h300 + 64'(i * 4), 1, 0, 0);
    step("flush", 1, 32'h1234_5013, 64'h30C, 1, 1, 0);
    step("post_flush", 0, 32'h0, 64'h0, 1, 0, 0);

    // Reset with a push at count=3
    for (int i = 0; i < 3; i++) step("pre_rst", 1, prog[i], 64'h400 + 64'(i * 4), 1, 0, 0);
    step("rst_push", 1, 32'h5555_5013, 64'h40C, 1, 0, 1);
    step("post_rst", 0, 32'h0, 64'h0, 1, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step("rand", bit'($urandom_range(0, 99) < 60), $urandom,
           {$urandom, $urandom}, bit'($urandom_range(0, 99) < 45),
           bit'($urandom_range(0, 99) < 4), bit'($urandom_range(0, 99) < 2));
    end
    step("final", 0, 32'h0, 64'h0, 1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
